// File: rtl/adsd_trace_pkg.sv
// Shared types and entry-layout helpers for the ADSD execution trace buffer.
package adsd_trace_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } trace_state_e;

    localparam int STATE_W = 2;

    // Entry layout, MSB first: {chg, port, op, pc}.
    function automatic int entry_width(input int port_w, input int op_w, input int pc_w);
        return 1 + port_w + op_w + pc_w;
    endfunction

    function automatic int chg_pos(input int port_w, input int op_w, input int pc_w);
        return port_w + op_w + pc_w;
    endfunction

    function automatic int port_lsb(input int op_w, input int pc_w);
        return op_w + pc_w;
    endfunction

    function automatic int op_lsb(input int pc_w);
        return pc_w;
    endfunction

endpackage

// File: rtl/adsd_trace_mem.sv
// Register-array trace storage: one synchronous write port, one asynchronous read port.
module adsd_trace_mem
    import adsd_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 29,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adsd_trace_buffer.sv
// Execution trace buffer: armed, optionally PC-triggered capture of retired
// instructions, stop-when-full or wrap mode, oldest-first valid/ready readout.
//
// Readout handshake: rd_valid is high in DONE while entries remain; an entry is
// consumed on every rising edge where rd_valid && rd_ready. rd_data holds the
// oldest entry and stays stable until that entry is consumed.
module adsd_trace_buffer
    import adsd_trace_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int OP_W   = 4,
    parameter int PORT_W = 8,
    parameter int DEPTH  = 16,
    localparam int ENTRY_W = entry_width(PORT_W, OP_W, PC_W),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               mode,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               stop,
    input  logic               valid_in,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [OP_W-1:0]    op_in,
    input  logic [PORT_W-1:0]  port_in,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [STATE_W-1:0] state
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CHG_POS  = chg_pos(PORT_W, OP_W, PC_W);
    localparam int PORT_LSB = port_lsb(OP_W, PC_W);
    localparam int OP_LSB   = op_lsb(PC_W);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    trace_state_e        state_q, state_d;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;
    logic                mode_q;
    logic [PORT_W-1:0]   last_port;

    logic                start;
    logic                wr_en;
    logic                pop;
    logic                full;
    logic                chg;
    logic [ENTRY_W-1:0]  wr_data;
    logic [ENTRY_W-1:0]  mem_rdata;

    assign full     = (cnt == FULL_CNT);
    assign rd_valid = (state_q == DONE) && (cnt != '0);
    // The first entry of a capture always flags a change; in wrap mode count
    // never drops back to zero during capture, so count==0 marks "first".
    assign chg      = (cnt == '0) || (port_in != last_port);

    // Assemble the entry being written from its field positions.
    always_comb begin
        wr_data = '0;
        wr_data[CHG_POS]                = chg;
        wr_data[PORT_LSB +: PORT_W]     = port_in;
        wr_data[OP_LSB +: OP_W]         = op_in;
        wr_data[PC_W-1:0]               = pc_in;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    start   = 1'b1;
                    state_d = trig_en ? WAIT_TRIG : CAPTURE;
                end
            end
            WAIT_TRIG: begin
                // stop wins over a trigger hit in the same cycle
                if (stop) begin
                    state_d = DONE;
                end else if (valid_in && (pc_in == trig_pc)) begin
                    wr_en   = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Stop-when-full mode leaves CAPTURE on the filling write,
                // so space always remains while in this state.
                if (valid_in) begin
                    wr_en = 1'b1;
                    if (!mode_q && (cnt == LAST_CNT)) begin
                        state_d = DONE;
                    end
                end
                if (stop) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (arm) begin
                    start   = 1'b1;
                    state_d = trig_en ? WAIT_TRIG : CAPTURE;
                end else if (rd_valid && rd_ready) begin
                    pop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, occupancy, overflow flag, capture mode and last captured port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            mode_q    <= 1'b0;
            last_port <= '0;
        end else if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            mode_q    <= mode;
            last_port <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_port <= port_in;
                if (full) begin
                    // wrap mode: the oldest entry is overwritten
                    rd_ptr <= rd_ptr + AW'(1);
                    ovf    <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                cnt    <= cnt - CNT_W'(1);
            end
        end
    end

    adsd_trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign rd_data  = (state_q == DONE) ? mem_rdata : '0;
    assign count    = cnt;
    assign overflow = ovf;
    assign state    = state_q;

endmodule

// File: tb/tb_adsd_trace_buffer.sv
// Bench for adsd_trace_buffer: queue-based reference model checked every cycle,
// a table-driven trigger sequence, hand-written corner cases and random traffic.
module tb_adsd_trace_buffer;

    localparam int PC_W   = 16;
    localparam int OP_W   = 4;
    localparam int PORT_W = 8;
    localparam int DEPTH  = 16;
    localparam int EW     = 1 + PORT_W + OP_W + PC_W;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              arm;
    logic              mode;
    logic              trig_en;
    logic [PC_W-1:0]   trig_pc;
    logic              stop;
    logic              valid_in;
    logic [PC_W-1:0]   pc_in;
    logic [OP_W-1:0]   op_in;
    logic [PORT_W-1:0] port_in;
    logic              rd_valid;
    logic              rd_ready;
    logic [EW-1:0]     rd_data;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [1:0]        state;

    adsd_trace_buffer #(
        .PC_W   (PC_W),
        .OP_W   (OP_W),
        .PORT_W (PORT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .mode     (mode),
        .trig_en  (trig_en),
        .trig_pc  (trig_pc),
        .stop     (stop),
        .valid_in (valid_in),
        .pc_in    (pc_in),
        .op_in    (op_in),
        .port_in  (port_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .state    (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int                n_vec = 0;
    int                n_err = 0;
    int                m_state;
    logic [EW-1:0]     exp_q[$];
    logic              m_ovf;
    logic              m_mode;
    logic              m_first;
    logic [PORT_W-1:0] m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        exp_q.delete();
        m_ovf   = 1'b0;
        m_mode  = 1'b0;
        m_first = 1'b1;
        m_last  = '0;
    endtask

    task automatic model_push();
        logic c;
        c = m_first ? 1'b1 : (port_in != m_last);
        exp_q.push_back({c, port_in, op_in, pc_in});
        m_first = 1'b0;
        m_last  = port_in;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        case (m_state)
            0, 3: begin
                if (arm) begin
                    exp_q.delete();
                    m_ovf   = 1'b0;
                    m_first = 1'b1;
                    m_mode  = mode;
                    m_state = trig_en ? 1 : 2;
                end else if (m_state == 3 && exp_q.size() > 0 && rd_ready) begin
                    void'(exp_q.pop_front());
                end
            end
            1: begin
                if (stop) m_state = 3;
                else if (valid_in && pc_in == trig_pc) begin
                    model_push();
                    m_state = 2;
                end
            end
            default: begin
                if (valid_in) begin
                    if (exp_q.size() == DEPTH) begin
                        void'(exp_q.pop_front());
                        m_ovf = 1'b1;
                    end
                    model_push();
                    if (!m_mode && exp_q.size() == DEPTH) m_state = 3;
                end
                if (stop) m_state = 3;
            end
        endcase
    endtask

    // Compare all outputs against the model mid-cycle, then clock once.
    task automatic tick();
        @(negedge clk);
        check("state", 64'(state), 64'(m_state));
        check("count", 64'(count), 64'(exp_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("rd_valid", 64'(rd_valid), 64'(m_state == 3 && exp_q.size() != 0));
        if (m_state == 3 && exp_q.size() != 0)
            check("rd_data", 64'(rd_data), 64'(exp_q[0]));
        else if (m_state != 3)
            check("rd_data_idle", 64'(rd_data), 64'(0));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        arm      = 1'b0;
        stop     = 1'b0;
        valid_in = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic do_arm(input logic md, input logic te);
        mode    = md;
        trig_en = te;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
    endtask

    task automatic retire(input int pc, input int port);
        valid_in = 1'b1;
        pc_in    = PC_W'(pc);
        op_in    = OP_W'($urandom_range(0, 15));
        port_in  = PORT_W'(port);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Pop n entries, expecting consecutive pcs from first_pc.
    task automatic drain(input int n, input int first_pc);
        rd_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check("drain_pc", 64'(rd_data[PC_W-1:0]), 64'(first_pc + k));
            tick();
        end
        rd_ready = 1'b0;
        check("drain_count", 64'(count), 64'(0));
    endtask

    // ---------------- trigger table ----------------
    typedef struct {
        logic            arm;
        logic            trig_en;
        logic            valid;
        logic            stop;
        logic [PC_W-1:0] pc;
        logic [1:0]      exp_state;
        logic [CW-1:0]   exp_count;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic a, input logic te, input logic v, input logic s,
                                input int pc, input int st, input int cnt);
        vec_t r;
        r.arm = a; r.trig_en = te; r.valid = v; r.stop = s;
        r.pc = PC_W'(pc); r.exp_state = 2'(st); r.exp_count = CW'(cnt);
        return r;
    endfunction

    int exp_front[4];
    int exp_cnt[4];
    logic rdy_seq[4];

    initial begin
        // table: arm with trigger at pc 7, retire 0..10, then stop
        tbl[0] = mk(1, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) tbl[1 + i] = mk(0, 1, 1, 0, i, 1, 0);
        tbl[8] = mk(0, 1, 1, 0, 7, 2, 1);
        for (int i = 0; i < 3; i++) tbl[9 + i] = mk(0, 1, 1, 0, 8 + i, 2, 2 + i);
        tbl[12] = mk(0, 1, 0, 1, 0, 3, 4);

        clear_in();
        mode = 0; trig_en = 0; trig_pc = '0; pc_in = '0; op_in = '0; port_in = '0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // ---- reset mid-capture ----
        do_arm(0, 0);
        for (int i = 0; i < 5; i++) retire(i, i);
        check("pre_reset_count", 64'(count), 64'(5));
        #1 rst = 1'b0;
        #1;
        check("rst_state", 64'(state), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // ---- mode 0, stop when full ----
        do_arm(0, 0);
        for (int i = 0; i < 20; i++) retire(i, (i == 0) ? 0 : i - 1);
        check("m0_state", 64'(state), 64'(3));
        check("m0_count", 64'(count), 64'(16));
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("m0_pc", 64'(rd_data[PC_W-1:0]), 64'(k));
            check("m0_chg", 64'(rd_data[EW-1]), 64'(k != 1));
            tick();
        end
        rd_ready = 1'b0;
        check("m0_end_count", 64'(count), 64'(0));
        check("m0_end_state", 64'(state), 64'(3));

        // ---- mode 1, wrap ----
        do_arm(1, 0);
        for (int i = 0; i < 20; i++) retire(i, $urandom_range(0, 3));
        do_stop();
        check("m1_count", 64'(count), 64'(16));
        check("m1_overflow", 64'(overflow), 64'(1));
        check("m1_state", 64'(state), 64'(3));
        drain(16, 4);

        // ---- table-driven trigger sequence ----
        trig_pc = 16'd7;
        mode    = 1'b0;
        for (int i = 0; i < 13; i++) begin
            arm      = tbl[i].arm;
            trig_en  = tbl[i].trig_en;
            valid_in = tbl[i].valid;
            stop     = tbl[i].stop;
            pc_in    = tbl[i].pc;
            port_in  = PORT_W'(i);
            tick();
            check("tbl_state", 64'(state), 64'(tbl[i].exp_state));
            check("tbl_count", 64'(count), 64'(tbl[i].exp_count));
        end
        clear_in();
        drain(4, 7);

        // ---- stop in the same cycle as the trigger hit ----
        do_arm(0, 1);
        for (int i = 0; i < 7; i++) retire(i, 0);
        valid_in = 1'b1; pc_in = 16'd7; stop = 1'b1;
        tick();
        clear_in();
        check("ts_state", 64'(state), 64'(3));
        check("ts_count", 64'(count), 64'(0));
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("ts_rd_valid", 64'(rd_valid), 64'(0));
            tick();
        end
        rd_ready = 1'b0;

        // ---- DONE with 3 entries, rd_ready 1,0,1,1 ----
        do_arm(0, 0);
        for (int i = 0; i < 3; i++) retire(100 + i, i);
        do_stop();
        exp_front = '{100, 101, 101, 102};
        exp_cnt   = '{2, 2, 1, 0};
        rdy_seq   = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int j = 0; j < 4; j++) begin
            rd_ready = rdy_seq[j];
            check("hs_front", 64'(rd_data[PC_W-1:0]), 64'(exp_front[j]));
            tick();
            check("hs_count", 64'(count), 64'(exp_cnt[j]));
        end
        rd_ready = 1'b0;

        // ---- arm ignored in CAPTURE, honoured in DONE ----
        do_arm(0, 0);
        for (int i = 0; i < 3; i++) retire(i, i);
        arm = 1'b1; valid_in = 1'b1; pc_in = 16'd3;
        tick();
        clear_in();
        check("arm_cap_state", 64'(state), 64'(2));
        check("arm_cap_count", 64'(count), 64'(4));
        do_stop();
        check("arm_done_count", 64'(count), 64'(4));
        do_arm(0, 0);
        check("rearm_state", 64'(state), 64'(2));
        check("rearm_count", 64'(count), 64'(0));
        do_stop();

        // ---- random traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            arm      = ($urandom_range(0, 19) == 0);
            mode     = 1'($urandom_range(0, 1));
            trig_en  = 1'($urandom_range(0, 1));
            trig_pc  = PC_W'($urandom_range(0, 7));
            stop     = ($urandom_range(0, 39) == 0);
            valid_in = ($urandom_range(0, 2) != 0);
            pc_in    = PC_W'($urandom_range(0, 7));
            op_in    = OP_W'($urandom_range(0, 15));
            port_in  = PORT_W'($urandom_range(0, 3));
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
